cone_sweep_ctrl: RTL and testbench
==================================

CONE_SWEEP_CTRL -- requirements
Module: cone_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, giving the cone input vector width (legal range 1..6).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles cone_in is held before sampling (legal range 1..15).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: begin a sweep; honoured only in IDLE.
REQ-007 Port abort, input, 1 bit: terminate a sweep in progress.
REQ-008 Port golden, input, 2^N_IN bits: expected cone response; bit k is the expected output for input vector k.
REQ-009 Port cone_in, output, N_IN bits: vector driven to the combinational cone under test.
REQ-010 Port cone_out, input, 1 bit: single output of the cone under test.
REQ-011 Port busy, output, 1 bit: high in SETTLE and SAMPLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-013 Port pass, output, 1 bit: sweep result; high when mismatch_cnt is 0 after a completed sweep.
REQ-014 Port truth, output, 2^N_IN bits: captured cone response, bit k holds the sample for vector k.
REQ-015 Port mismatch_cnt, output, N_IN+1 bits: number of sampled bits that differ from golden.

Function
REQ-016 The block SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL latch golden, clear truth, mismatch_cnt, pass and vec, load settle_cnt=SETTLE_CYCLES, and enter SETTLE.
REQ-018 In SETTLE the block SHALL drive cone_in=vec and decrement settle_cnt; it SHALL enter SAMPLE after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-019 In SAMPLE the block SHALL write cone_out into truth[vec] and increment mismatch_cnt when cone_out differs from latched golden[vec]; cone_in SHALL still equal vec.
REQ-020 From SAMPLE with vec < 2^N_IN-1, the block SHALL increment vec, reload settle_cnt and enter SETTLE; with vec = 2^N_IN-1 it SHALL enter DONE without wrapping vec.
REQ-021 In DONE the block SHALL assert done for exactly one cycle, register pass=(mismatch_cnt==0) including the final sample, and return to IDLE.
REQ-022 Latency SHALL be: with start sampled at edge 0, done is high in cycle 2^N_IN*(SETTLE_CYCLES+1)+1 (97 for the defaults).
REQ-023 cone_in SHALL be 0 in IDLE and DONE.
REQ-024 truth, mismatch_cnt and pass SHALL hold their values in IDLE until the next accepted start.
REQ-025 start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 abort=1 in SETTLE or SAMPLE SHALL return the block to IDLE on the next edge with pass=0 and no done pulse; truth and mismatch_cnt SHALL keep their partial values; that cycle's SAMPLE write SHALL be suppressed.
REQ-027 abort SHALL take priority over start when both are high in IDLE; the sweep SHALL NOT start.
REQ-028 abort in IDLE or DONE SHALL have no effect; the done pulse from DONE SHALL still occur.
REQ-029 Changes on golden after start is accepted SHALL NOT affect the current sweep.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter IDLE with cone_in=0, busy=0, done=0, pass=0, truth=0, mismatch_cnt=0, vec=0 and settle_cnt=0, from any state.
REQ-031 rst SHALL take priority over start and abort.

Verification
REQ-032 Defaults, cone model = AND of inputs 0 and 1, golden=32'h88888888, start pulse -> done in cycle 97, truth=32'h88888888, mismatch_cnt=0, pass=1.
REQ-033 Defaults, cone_out tied to 0, golden=32'h00000003 -> truth=0, mismatch_cnt=2, pass=0, done for one cycle.
REQ-034 abort in cycle 10 of a sweep -> IDLE in cycle 11, busy=0, no done pulse, pass=0, cone_in=0.
REQ-035 start re-pulsed in cycles 5 and 96 of a sweep -> single done in cycle 97 and no second sweep; start in cycle 98 -> new sweep with done in cycle 195.
REQ-036 rst in cycle 40 of a sweep -> all outputs 0 in the next cycle; a following start runs a full sweep correctly.
REQ-037 SETTLE_CYCLES=1, N_IN=3, cone_out = parity(cone_in), golden=8'h96 -> done in cycle 17, pass=1.

Source files
------------

// File: rtl/cone_sweep_ctrl.sv
// Exhaustive sweep controller for a small combinational cone: it drives every input vector,
// waits for the cone to settle, samples the output, and compares it against a latched golden table.
module cone_sweep_ctrl #(
    parameter int N_IN          = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [(1<<N_IN)-1:0]     golden,
    output logic [N_IN-1:0]          cone_in,
    input  logic                     cone_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [(1<<N_IN)-1:0]     truth,
    output logic [N_IN:0]            mismatch_cnt
);

    localparam int                N_VEC       = 1 << N_IN;
    localparam logic [N_IN-1:0]   LAST_VEC    = '1;
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t               state_q;
    logic [N_VEC-1:0]     golden_q;
    logic [N_VEC-1:0]     truth_q;
    logic [N_IN:0]        mismatch_cnt_q;
    logic [N_IN-1:0]      vec_q;
    logic [3:0]           settle_cnt_q;
    logic [N_IN-1:0]      cone_in_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;

    logic [N_VEC-1:0]     truth_d;
    logic [N_IN:0]        mismatch_cnt_d;
    logic [N_IN-1:0]      vec_d;
    logic                 miss;

    // NOTE: always_comb uses blocking '=' and assigns a default before any partial update,
    // so no latch is inferred; the always_ff below uses only non-blocking '<='.
    always_comb begin
        truth_d        = truth_q;
        truth_d[vec_q] = cone_out;
        miss           = cone_out ^ golden_q[vec_q];
        mismatch_cnt_d = mismatch_cnt_q + (N_IN+1)'(miss);
        vec_d          = vec_q + N_IN'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            golden_q       <= '0;
            truth_q        <= '0;
            mismatch_cnt_q <= '0;
            vec_q          <= '0;
            settle_cnt_q   <= '0;
            cone_in_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        golden_q       <= golden;
                        truth_q        <= '0;
                        mismatch_cnt_q <= '0;
                        pass_q         <= 1'b0;
                        vec_q          <= '0;
                        settle_cnt_q   <= SETTLE_LOAD;
                        cone_in_q      <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        cone_in_q <= '0;
                        pass_q    <= 1'b0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                        if (settle_cnt_q == 4'd1) begin
                            state_q <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    // An aborted sample cycle leaves truth and the count untouched.
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        cone_in_q <= '0;
                        pass_q    <= 1'b0;
                    end else begin
                        truth_q        <= truth_d;
                        mismatch_cnt_q <= mismatch_cnt_d;
                        if (vec_q == LAST_VEC) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            cone_in_q <= '0;
                            pass_q    <= (mismatch_cnt_d == '0);
                        end else begin
                            vec_q        <= vec_d;
                            cone_in_q    <= vec_d;
                            settle_cnt_q <= SETTLE_LOAD;
                            state_q      <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cone_in      = cone_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign truth        = truth_q;
    assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_cone_sweep_ctrl.sv
// Directed bench for cone_sweep_ctrl: a default-sized instance with a selectable cone model
// and a 3-input instance with a parity cone and single-cycle settle.
module tb_cone_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;

    logic [31:0] golden = '0;
    logic [4:0]  cone_in;
    logic        cone_out;
    logic        busy, done, pass;
    logic [31:0] truth;
    logic [5:0]  mismatch_cnt;

    logic [7:0]  golden3 = 8'h96;
    logic [2:0]  cone_in3;
    logic        cone_out3;
    logic        busy3, done3, pass3;
    logic [7:0]  truth3;
    logic [3:0]  mismatch_cnt3;

    // 0: AND of inputs 0 and 1, 1: output tied low
    int          cone_mode = 0;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          cyc;
    int          st_a, st_b, st_c, st_d, ab_c, ab_d, rs_c;
    int          n_done, first_done, n_done3, first_done3;

    always #5 clk = ~clk;

    assign cone_out  = (cone_mode == 0) ? (cone_in[0] & cone_in[1]) : 1'b0;
    assign cone_out3 = ^cone_in3;

    cone_sweep_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .golden       (golden),
        .cone_in      (cone_in),
        .cone_out     (cone_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .truth        (truth),
        .mismatch_cnt (mismatch_cnt)
    );

    cone_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .golden       (golden3),
        .cone_in      (cone_in3),
        .cone_out     (cone_out3),
        .busy         (busy3),
        .done         (done3),
        .pass         (pass3),
        .truth        (truth3),
        .mismatch_cnt (mismatch_cnt3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reset pulse; the cycle right after it is cycle 0 and its inputs are sampled at edge 0.
    task automatic reset_dut();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        st_a = -1; st_b = -1; st_c = -1; st_d = -1;
        ab_c = -1; ab_d = -1; rs_c = -1;
        n_done = 0; first_done = -1;
        n_done3 = 0; first_done3 = -1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            start = (cyc == st_a) || (cyc == st_b) || (cyc == st_c) || (cyc == st_d);
            abort = (cyc == ab_c) || (cyc == ab_d);
            rst   = (cyc == rs_c);
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
            if (done3) begin
                n_done3++;
                if (first_done3 < 0) first_done3 = cyc;
            end
        end
    endtask

    initial begin
        // Reset state
        reset_dut();
        check("rst_cone_in", 64'(cone_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_truth", 64'(truth), 64'd0);
        check("rst_mm", 64'(mismatch_cnt), 64'd0);
        check("rst_busy3", 64'(busy3), 64'd0);

        // AND cone, matching golden; golden disturbed mid-sweep; abort during DONE
        cone_mode = 0;
        golden = 32'h8888_8888;
        st_a = 0;
        ab_c = 97;
        run_to(1);
        check("and_busy_c1", 64'(busy), 64'd1);
        check("and_cone_in_c1", 64'(cone_in), 64'd0);
        run_to(4);
        check("and_cone_in_c4", 64'(cone_in), 64'd1);
        run_to(7);
        check("and_cone_in_c7", 64'(cone_in), 64'd2);
        run_to(50);
        golden = 32'h0;
        run_to(96);
        check("and_no_done_c96", 64'(done), 64'd0);
        run_to(97);
        check("and_done_c97", 64'(done), 64'd1);
        check("and_cone_in_done", 64'(cone_in), 64'd0);
        run_to(98);
        check("and_done_once", 64'(n_done), 64'd1);
        check("and_truth", 64'(truth), 64'h8888_8888);
        check("and_mm", 64'(mismatch_cnt), 64'd0);
        check("and_pass", 64'(pass), 64'd1);
        check("and_busy_idle", 64'(busy), 64'd0);
        run_to(110);
        check("and_pass_hold", 64'(pass), 64'd1);
        check("and_truth_hold", 64'(truth), 64'h8888_8888);

        // Cone tied low against golden 0x3
        reset_dut();
        cone_mode = 1;
        golden = 32'h0000_0003;
        st_a = 0;
        run_to(98);
        check("zero_first_done", 64'(first_done), 64'd97);
        check("zero_n_done", 64'(n_done), 64'd1);
        check("zero_truth", 64'(truth), 64'd0);
        check("zero_mm", 64'(mismatch_cnt), 64'd2);
        check("zero_pass", 64'(pass), 64'd0);

        // Abort in SETTLE, abort beating start in IDLE, abort in SAMPLE
        reset_dut();
        cone_mode = 1;
        golden = 32'hFFFF_FFFF;
        st_a = 0;
        ab_c = 10;
        run_to(10);
        check("abort_busy_c10", 64'(busy), 64'd1);
        check("abort_mm_c10", 64'(mismatch_cnt), 64'd3);
        run_to(11);
        check("abort_busy_c11", 64'(busy), 64'd0);
        check("abort_cone_in_c11", 64'(cone_in), 64'd0);
        check("abort_pass_c11", 64'(pass), 64'd0);
        check("abort_done_c11", 64'(done), 64'd0);
        check("abort_mm_kept", 64'(mismatch_cnt), 64'd3);
        st_b = 20;
        ab_d = 20;
        run_to(21);
        check("abort_prio_busy", 64'(busy), 64'd0);
        st_c = 25;
        ab_c = 37;
        run_to(37);
        check("abort_sample_busy", 64'(busy), 64'd1);
        run_to(38);
        check("abort_sample_mm", 64'(mismatch_cnt), 64'd3);
        check("abort_sample_busy_off", 64'(busy), 64'd0);
        run_to(140);
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_mm_hold", 64'(mismatch_cnt), 64'd3);

        // Start re-pulsed while busy and while in SAMPLE, then a fresh start in IDLE
        reset_dut();
        cone_mode = 0;
        golden = 32'h8888_8888;
        st_a = 0;
        st_b = 5;
        st_c = 96;
        st_d = 98;
        run_to(194);
        check("restart_first_done", 64'(first_done), 64'd97);
        check("restart_n_done", 64'(n_done), 64'd1);
        run_to(195);
        check("restart_done_c195", 64'(done), 64'd1);
        run_to(196);
        check("restart_pass", 64'(pass), 64'd1);
        check("restart_truth", 64'(truth), 64'h8888_8888);

        // Reset mid-sweep, with start in the same cycle, then a full sweep
        reset_dut();
        cone_mode = 1;
        golden = 32'hFFFF_FFFF;
        st_a = 0;
        st_b = 40;
        rs_c = 40;
        run_to(40);
        check("midrst_mm_c40", 64'(mismatch_cnt), 64'd13);
        run_to(41);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_pass", 64'(pass), 64'd0);
        check("midrst_truth", 64'(truth), 64'd0);
        check("midrst_mm", 64'(mismatch_cnt), 64'd0);
        check("midrst_cone_in", 64'(cone_in), 64'd0);
        cone_mode = 0;
        golden = 32'h8888_8888;
        st_c = 45;
        run_to(141);
        check("midrst_no_early_done", 64'(n_done), 64'd0);
        run_to(142);
        check("midrst_done_c142", 64'(done), 64'd1);
        run_to(143);
        check("midrst_pass_after", 64'(pass), 64'd1);
        check("midrst_truth_after", 64'(truth), 64'h8888_8888);
        check("midrst_mm_after", 64'(mismatch_cnt), 64'd0);

        // Small instance: parity cone, one settle cycle
        reset_dut();
        golden3 = 8'h96;
        st_a = 0;
        run_to(18);
        check("par_first_done", 64'(first_done3), 64'd17);
        check("par_n_done", 64'(n_done3), 64'd1);
        check("par_truth", 64'(truth3), 64'h96);
        check("par_mm", 64'(mismatch_cnt3), 64'd0);
        check("par_pass", 64'(pass3), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
